// File: rtl/seq_mini_alu_if.sv
// Operation request and result bus for seq_mini_alu.
// The master drives requests; the ALU drives status and results back.
interface seq_mini_alu_if #(
   parameter int WIDTH        = 4,
   parameter int RESULT_WIDTH = 20
);
   logic                    start;
   logic [WIDTH-1:0]        op1;
   logic [WIDTH-1:0]        op2;
   logic [2:0]              opcode;
   logic                    busy;
   logic                    done;
   logic [RESULT_WIDTH-1:0] result;
   logic                    negative;
   logic                    error;

   modport master (
      output start, op1, op2, opcode,
      input  busy, done, result, negative, error
   );

   modport slave (
      input  start, op1, op2, opcode,
      output busy, done, result, negative, error
   );
endinterface

// File: rtl/seq_mini_alu.sv
// Multi-cycle mini ALU: add, sub, bit-serial shifts and shift-add multiply.
// One operation per accepted start; a one-cycle done pulse marks the held result.
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | operation running; cnt counts down the remaining steps
// DONE  | done pulse cycle; start here launches the next operation
module seq_mini_alu #(
   parameter int WIDTH        = 4,
   parameter int RESULT_WIDTH = 20
) (
   input logic          clk,
   input logic          rst,
   seq_mini_alu_if.slave bus
);

   generate
      if (WIDTH < 2 || RESULT_WIDTH < 2 * WIDTH) begin : g_param_check
         $error("seq_mini_alu: need WIDTH >= 2 and RESULT_WIDTH >= 2*WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [2:0]       OP_ADD   = 3'b000;
   localparam logic [2:0]       OP_SUB   = 3'b001;
   localparam logic [2:0]       OP_SHL   = 3'b010;
   localparam logic [2:0]       OP_SHR   = 3'b011;
   localparam logic [2:0]       OP_MUL   = 3'b100;
   localparam logic [WIDTH-1:0] MUL_LAST = WIDTH'(WIDTH - 1);

   state_t                  state;
   logic [2:0]              opc;
   logic [RESULT_WIDTH-1:0] acc;
   logic [RESULT_WIDTH-1:0] mcand;
   logic [WIDTH-1:0]        mplier;
   logic [WIDTH-1:0]        cnt;

   logic [RESULT_WIDTH-1:0] op2_ext;
   logic [RESULT_WIDTH-1:0] step;
   logic                    neg_now;
   logic                    err_now;

   assign op2_ext = RESULT_WIDTH'(mplier);

   // mcand/mplier double as the latched op1/op2 for add and sub, which finish
   // before either register is ever shifted.
   always_comb begin
      step    = acc;
      neg_now = 1'b0;
      err_now = 1'b0;
      case (opc)
         OP_ADD: step = mcand + op2_ext;
         OP_SUB: begin
            step    = mcand - op2_ext;
            neg_now = (mcand < op2_ext);
         end
         OP_SHL: if (mplier != '0) step = acc << 1;
         OP_SHR: if (mplier != '0) step = acc >> 1;
         OP_MUL: step = mplier[0] ? (acc + mcand) : acc;
         default: begin
            step    = '0;
            err_now = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         opc          <= '0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         cnt          <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.result   <= '0;
         bus.negative <= 1'b0;
         bus.error    <= 1'b0;
      end else begin
         case (state)
            EXEC: begin
               if (cnt == '0) begin
                  bus.result   <= step;
                  bus.negative <= neg_now;
                  bus.error    <= err_now;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
                  acc <= step;
                  if (opc == OP_MUL) begin
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
               end
            end
            default: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  opc    <= bus.opcode;
                  mcand  <= RESULT_WIDTH'(bus.op1);
                  mplier <= bus.op2;
                  acc    <= (bus.opcode == OP_MUL) ? '0 : RESULT_WIDTH'(bus.op1);
                  case (bus.opcode)
                     OP_SHL, OP_SHR: cnt <= (bus.op2 == '0) ? '0 : bus.op2 - 1'b1;
                     OP_MUL:         cnt <= MUL_LAST;
                     default:        cnt <= '0;
                  endcase
                  bus.busy <= 1'b1;
                  state    <= EXEC;
               end else begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/seq_mini_alu.md
Name: seq_mini_alu

Overview:
- Parametrised, clocked successor to the combinational mini ALU.
- Accepts one operation per start pulse and runs it as a multi-cycle operation: add, subtract, iterative shift left/right, or iterative shift-add multiply.
- Reports completion with a one-cycle done pulse and holds the registered result.
- Drives the same wide result bus that feeds the board's display decoding.

Parameters:
- WIDTH, 4: operand width in bits; minimum 2.
- RESULT_WIDTH, 20: result width in bits; must be at least 2*WIDTH. Elaboration error otherwise.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when accepting (see below).
- op1  input  WIDTH  first operand, unsigned.
- op2  input  WIDTH  second operand, unsigned; the shift amount for shifts.
- opcode  input  3  3'b000 add, 3'b001 sub, 3'b010 shl, 3'b011 shr, 3'b100 mul; 3'b101 to 3'b111 invalid.
- busy  output  1  high while an operation executes.
- done  output  1  one-cycle pulse: result and flags are valid.
- result  output  RESULT_WIDTH  registered result.
- negative  output  1  set when a sub result is below zero.
- error  output  1  set when an invalid opcode was accepted.

Behaviour:
- Reset:
  - rst high at a clock edge forces state IDLE.
  - busy, done, result, negative and error all go to 0.
  - Internal counter and accumulator are cleared.
  - Reset overrides start and aborts any in-flight operation with no done pulse.
- States: IDLE, EXEC, DONE.
- Accept:
  - start=1 at an edge while in IDLE or DONE latches op1, op2 and opcode into internal registers.
  - State goes to EXEC; busy is 1 from the next cycle.
  - Back-to-back operations from DONE are allowed.
  - start in EXEC is ignored; inputs are not sampled again.
- Input stability: inputs may change freely after the accept edge and do not affect the operation in flight.
- EXEC duration, counted in cycles after the accept edge:
  - add and sub: 1 cycle.
  - shl and shr: max(op2, 1) cycles, one bit of shift per cycle.
  - mul: WIDTH cycles, one shift-add step per cycle over the op2 bits, LSB first.
  - invalid opcode: 1 cycle.
- Completion:
  - On the last EXEC edge, result, negative and error are updated and state goes to DONE.
  - done=1 and busy=0 for exactly the cycle in DONE.
  - DONE returns to IDLE next unless start=1, in which case it goes to EXEC.
- Output hold: result and the flags hold their values until the next completion or reset. They do not change at accept and do not change during EXEC.
- Arithmetic, with all operands zero-extended to RESULT_WIDTH:
  - add: result = op1 + op2.
  - sub: result = op1 - op2, two's complement modulo 2^RESULT_WIDTH; negative = (op1 < op2).
  - shl: result = op1 << op2. Bits shifted past the MSB are lost, so no wrap-around.
  - shr: logical shift, result = op1 >> op2.
  - mul: result = op1 * op2, full 2*WIDTH product zero-extended.
- Flags:
  - negative is 0 for every opcode except sub.
  - error: for an invalid opcode, result = 0, negative = 0, error = 1. error is 0 for every valid opcode.
- Shift by 0: takes 1 cycle and result = op1.

Test Plan:
- Reset, then op1=1, op2=1, add, start for 1 cycle -> done 2 cycles after the start edge; result=2, negative=0, busy high for 1 cycle.
- op1=2, op2=1, sub -> result=1, negative=0. Then op1=1, op2=2, sub -> result=20'hFFFFF, negative=1.
- op1=8, op2=2, shl -> busy for 2 cycles, result=32 (20'h00020). Then shr with the same operands -> result=2. shl with op2=0 -> 1 cycle, result=8.
- op1=15, op2=15, mul, with WIDTH=4 -> busy for exactly 4 cycles, result=225. Changing op1, op2 and opcode and pulsing start during EXEC -> result still 225, no extra done.
- Back-to-back: start held high through DONE with add of 3+4 -> second done exactly 2 cycles after the first; result=7. Then opcode 3'b110 -> error=1, result=0.
- mul 15*15 started, rst asserted on the 2nd EXEC cycle -> no done pulse; all outputs 0 the cycle after the reset edge; next add 1+1 -> result=2.
